// File: rtl/cra_seq.sv
// -----------------------------------------------------------------------------
// cra_seq -- microcode address sequencer for the EBOX control-RAM path.
//
// Forms the next control-RAM address each advancing microcycle from the CRAM J
// field, the dispatch select and the DRAM/test/normalize inputs. It also keeps
// the microcode subroutine CALL/RETURN stack and forces page-fail traps.
//
// Ports:
//   clk             microcycle clock, all state changes on its rising edge
//   rst_n           synchronous active-low reset
//   adv             advance enable; 0 holds every piece of state
//   cram_j          CRAM J field
//   cram_disp       dispatch select (J, DRAM_J, DRAM_A, DRAM_B, NORM, SKIP, RETURN)
//   cram_call       push the current microaddress this cycle
//   dram_a/dram_b   DRAM A/B fields, ORed into the low three J bits
//   dram_j          DRAM J field, used whole
//   test_satisfied  skip condition, ORed into J bit 0
//   norm            normalize priority code, ORed into the low three J bits
//   page_fail       trap request, highest priority
//   cra_adr         current microaddress (registered)
//   stack_depth     number of occupied stack entries
//   stack_ovf       sticky overflow flag
//   stack_unf       sticky underflow flag
// -----------------------------------------------------------------------------
module cra_seq #(
    parameter int                ADDR_W      = 11,
    parameter int                STACK_DEPTH = 16,
    parameter logic [ADDR_W-1:0] RESET_ADDR  = '0,
    parameter logic [ADDR_W-1:0] PF_ADDR     = 11'o1777
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           adv,
    input  logic [ADDR_W-1:0]              cram_j,
    input  logic [2:0]                     cram_disp,
    input  logic                           cram_call,
    input  logic [2:0]                     dram_a,
    input  logic [2:0]                     dram_b,
    input  logic [ADDR_W-1:0]              dram_j,
    input  logic                           test_satisfied,
    input  logic [2:0]                     norm,
    input  logic                           page_fail,
    output logic [ADDR_W-1:0]              cra_adr,
    output logic [$clog2(STACK_DEPTH):0]   stack_depth,
    output logic                           stack_ovf,
    output logic                           stack_unf
);

    localparam int                PTR_W   = $clog2(STACK_DEPTH);
    localparam int                DEP_W   = PTR_W + 1;
    localparam logic [PTR_W-1:0]  PTR_ONE = PTR_W'(1);
    localparam logic [DEP_W-1:0]  DEP_ONE = DEP_W'(1);
    localparam logic [DEP_W-1:0]  FULL    = DEP_W'(STACK_DEPTH);

    typedef enum logic [2:0] {
        DISP_J      = 3'd0,
        DISP_DRAM_J = 3'd1,
        DISP_DRAM_A = 3'd2,
        DISP_DRAM_B = 3'd3,
        DISP_NORM   = 3'd4,
        DISP_SKIP   = 3'd5,
        DISP_RETURN = 3'd6,
        DISP_RSVD   = 3'd7
    } disp_e;

    // r_ptr indexes the next free slot; top of stack lives at r_ptr - 1.
    logic [ADDR_W-1:0] r_adr;
    logic [PTR_W-1:0]  r_ptr;
    logic [DEP_W-1:0]  r_depth;
    logic              r_ovf;
    logic              r_unf;
    logic [ADDR_W-1:0] r_stack [STACK_DEPTH];

    disp_e             w_disp;
    logic              w_push;
    logic              w_pop;
    logic              w_empty;
    logic [ADDR_W-1:0] w_top;
    logic [ADDR_W-1:0] w_next;
    logic [PTR_W-1:0]  w_ptr_pop;
    logic [PTR_W-1:0]  w_ptr_nxt;
    logic [DEP_W-1:0]  w_depth_pop;
    logic [DEP_W-1:0]  w_depth_nxt;
    logic              w_ovf_set;
    logic              w_unf_set;

    assign w_disp  = disp_e'(cram_disp);
    assign w_empty = (r_depth == '0);
    // An empty stack reads as zero, so an underflowing RETURN lands on cram_j.
    assign w_top   = w_empty ? '0 : r_stack[r_ptr - PTR_ONE];
    // A page fail wins over everything: it always pushes and never pops.
    assign w_push  = page_fail | cram_call;

    always_comb begin
        // NOTE: every signal gets a default before any branch, so no path can
        // leave one unassigned and infer a latch.
        w_next      = cram_j;
        w_pop       = 1'b0;
        w_ptr_pop   = r_ptr;
        w_depth_pop = r_depth;
        w_unf_set   = 1'b0;
        w_ptr_nxt   = r_ptr;
        w_depth_nxt = r_depth;
        w_ovf_set   = 1'b0;

        if (page_fail) begin
            w_next = PF_ADDR;
        end else begin
            unique case (w_disp)
                DISP_DRAM_J: w_next = dram_j;
                DISP_DRAM_A: w_next = cram_j | ADDR_W'(dram_a);
                DISP_DRAM_B: w_next = cram_j | ADDR_W'(dram_b);
                DISP_NORM:   w_next = cram_j | ADDR_W'(norm);
                DISP_SKIP:   w_next = cram_j | ADDR_W'(test_satisfied);
                DISP_RETURN: begin
                    w_next = w_top | cram_j;
                    w_pop  = 1'b1;
                end
                default:     w_next = cram_j;  // J and the reserved code
            endcase
        end

        // Pop first, then push onto the popped state: a CALL together with a
        // RETURN therefore overwrites the top entry and leaves depth unchanged.
        if (w_pop) begin
            if (w_empty) begin
                w_unf_set = 1'b1;
            end else begin
                w_ptr_pop   = r_ptr - PTR_ONE;
                w_depth_pop = r_depth - DEP_ONE;
            end
        end

        w_ptr_nxt   = w_ptr_pop;
        w_depth_nxt = w_depth_pop;
        if (w_push) begin
            // The pointer wraps, so pushing onto a full stack overwrites the
            // oldest entry.
            w_ptr_nxt = w_ptr_pop + PTR_ONE;
            if (w_depth_pop == FULL) begin
                w_ovf_set = 1'b1;
            end else begin
                w_depth_nxt = w_depth_pop + DEP_ONE;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_adr   <= RESET_ADDR;
            r_ptr   <= '0;
            r_depth <= '0;
            r_ovf   <= 1'b0;
            r_unf   <= 1'b0;
        end else if (adv) begin
            r_adr   <= w_next;
            r_ptr   <= w_ptr_nxt;
            r_depth <= w_depth_nxt;
            r_ovf   <= r_ovf | w_ovf_set;
            r_unf   <= r_unf | w_unf_set;
        end
    end

    // NOTE: the stack array is deliberately not reset; the depth counter alone
    // defines which entries are valid, which keeps it mappable to RAM.
    always_ff @(posedge clk) begin
        if (rst_n && adv && w_push) begin
            r_stack[w_ptr_pop] <= r_adr;
        end
    end

    assign cra_adr     = r_adr;
    assign stack_depth = r_depth;
    assign stack_ovf   = r_ovf;
    assign stack_unf   = r_unf;

endmodule

// File: doc/cra_seq.md
# cra_seq

Microcode address sequencer for the EBOX control-RAM path. It sits directly downstream of the instruction register and DRAM dispatch stage and consumes the DRAM A/B/J fields, TEST_SATISFIED and NORM that stage produces. Together with the current CRAM J and dispatch fields, it forms the next control-RAM address each microcycle. It also maintains the microcode subroutine CALL/RETURN stack and forces page-fail traps.

## Interface
Parameters:
- ADDR_W, 11, control-RAM address width.
- STACK_DEPTH, 16, subroutine stack entries; must be a power of two.
- RESET_ADDR, 0, microaddress loaded by reset.
- PF_ADDR, 11'o1777, page-fail trap microaddress.

Ports:
- clk  in  1  microcycle clock; all state changes on its rising edge.
- rst_n  in  1  synchronous, active-low reset.
- adv  in  1  advance enable; 0 holds all state.
- cram_j  in  ADDR_W  CRAM J field.
- cram_disp  in  3  dispatch select, encoding below.
- cram_call  in  1  push return address this cycle.
- dram_a  in  3  DRAM A field.
- dram_b  in  3  DRAM B field.
- dram_j  in  ADDR_W  DRAM J field.
- test_satisfied  in  1  skip condition.
- norm  in  3  normalize priority code.
- page_fail  in  1  page-fail trap request.
- cra_adr  out  ADDR_W  current microaddress (registered).
- stack_depth  out  $clog2(STACK_DEPTH)+1  occupied entries.
- stack_ovf  out  1  sticky overflow flag.
- stack_unf  out  1  sticky underflow flag.

## Operation
Next-address selection, evaluated only when adv=1. Priority runs from page fail down.
- **page_fail=1:** next = PF_ADDR.
  - Push cra_adr.
  - cram_disp and cram_call are ignored.
- **cram_disp 0 (J):** next = cram_j.
- **cram_disp 1 (DRAM_J):** next = dram_j.
- **cram_disp 2 (DRAM_A):** next = cram_j with bits [2:0] ORed with dram_a.
- **cram_disp 3 (DRAM_B):** next = cram_j with bits [2:0] ORed with dram_b.
- **cram_disp 4 (NORM):** next = cram_j with bits [2:0] ORed with norm.
- **cram_disp 5 (SKIP):** next = cram_j with bit 0 ORed with test_satisfied.
- **cram_disp 6 (RETURN):**
  - next = top-of-stack ORed with cram_j.
  - Pop the stack.
- **cram_disp 7:** reserved; behaves as 0.
- **cram_call=1 (no page fail):** push cra_adr; this is independent of the dispatch value.
- **Call and RETURN in the same cycle:** pop then push. The top entry is replaced with cra_adr, depth is unchanged, and next = old top ORed with cram_j.
- **Page fail with RETURN:** no pop; push only.

Stack is a circular buffer with a pointer and a depth counter.
- **Push when depth = STACK_DEPTH:**
  - The oldest entry is overwritten.
  - Depth stays at STACK_DEPTH.
  - stack_ovf is set.
- **Pop when depth = 0:**
  - The popped value is treated as 0, so next = cram_j.
  - Depth stays 0.
  - stack_unf is set.
- **Flag clearing:** stack_ovf and stack_unf are cleared only by reset.

## Timing
- **Reset:** when rst_n=0 at a clk edge:
  - cra_adr = RESET_ADDR.
  - stack_depth = 0, stack pointer = 0.
  - stack_ovf = 0, stack_unf = 0.
  - Stack contents are don't-care.
  - Reset overrides adv and all other inputs, including mid-call or mid-trap.
- **Latency:** 1 cycle. Inputs are sampled at edge N, and cra_adr reflects the new address after edge N. There is no combinational path from any input to any output.
- **adv=0:** cra_adr, stack, depth and flags all hold. page_fail is ignored, not latched; it must be held until an adv=1 cycle.
- **Pushed value:** the cra_adr value present before the edge, i.e. the address of the executing microinstruction.
- **Back-to-back CALLs:** one push per adv cycle.
- **RETURN immediately after CALL:** returns the just-pushed value.
- **Stack storage:** may be flops or distributed RAM, provided the read of top-of-stack is combinational within the cycle.

## Test plan
- **Reset and J:**
  - Apply rst_n=0 for 2 cycles, then release → cra_adr=0, flags 0, depth 0.
  - Drive disp=0, cram_j=11'o0123 with adv=1 → cra_adr=11'o0123 next cycle.
  - Drop adv → cra_adr holds.
- **Dispatch ORing:**
  - cram_j=11'o0200, disp=2, dram_a=5 → 11'o0205.
  - disp=4, norm=3 → 11'o0203.
  - disp=5, cram_j=11'o0310, test_satisfied=1 → 11'o0311; with test_satisfied=0 → 11'o0310.
  - disp=1, dram_j=11'o1234 → 11'o1234.
- **Call/return:**
  - At cra_adr=11'o0050, call with cram_j=11'o0400 → cra_adr=11'o0400, depth 1.
  - Then RETURN with cram_j=1 → cra_adr=11'o0051, depth 0.
  - Call plus RETURN in the same cycle at depth 1 → depth remains 1; next = old top ORed with cram_j.
- **Page fail:**
  - At cra_adr=11'o0777, assert page_fail with disp=6, call=1 → cra_adr=PF_ADDR, depth +1, no pop.
  - A following RETURN with cram_j=0 → 11'o0777.
- **Overflow/underflow:**
  - Perform 17 pushes of distinct addresses → stack_ovf=1, depth=16.
  - Perform 16 pops → returns pushes 17..2 in order.
  - A 17th pop → stack_unf=1, next = cram_j.
- **Reset mid-operation:**
  - With depth 5 and flags set, assert rst_n=0 for one edge → all outputs return to reset values.
  - A subsequent RETURN → stack_unf=1.
